// File: rtl/pc_fetch_ctrl.sv
// Program counter and next-PC controller for the fetch unit.
// Selects jump, branch or sequential targets, traps misaligned targets and counts PC updates.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000,
  parameter int          COUNT_WIDTH  = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [31:0]            PCAddResult,
  input  logic                   BranchTaken,
  input  logic [31:0]            BranchTarget,
  input  logic                   Jump,
  input  logic [31:0]            JumpTarget,
  input  logic                   Stall,
  input  logic                   ImemReady,
  input  logic                   ErrClear,
  output logic [31:0]            PCResult,
  output logic                   FetchReq,
  output logic                   MisalignErr,
  output logic [COUNT_WIDTH-1:0] FetchCount,
  output logic [1:0]             State
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_ERROR = 2'b10
  } state_t;

  state_t                 state_r;
  logic [31:0]            pc_r;
  logic                   fetch_req_r;
  logic                   misalign_r;
  logic [COUNT_WIDTH-1:0] count_r;

  logic [31:0]            next_pc_s;
  logic                   take_s;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

  // Next-PC source select: Jump beats BranchTaken beats the sequential adder.
  always_comb begin
    next_pc_s = PCAddResult;
    take_s    = 1'b0;
    if (Jump) begin
      next_pc_s = JumpTarget;
      take_s    = 1'b1;
    end else if (BranchTaken) begin
      next_pc_s = BranchTarget;
      take_s    = 1'b1;
    end else begin
      next_pc_s = PCAddResult;
      take_s    = ImemReady;
    end
  end

  // Fetch FSM with PC, counter and Moore outputs all registered together.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r     <= ST_IDLE;
      pc_r        <= RESET_VECTOR;
      fetch_req_r <= 1'b0;
      misalign_r  <= 1'b0;
      count_r     <= {COUNT_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r     <= ST_FETCH;
          fetch_req_r <= 1'b1;
        end
        ST_FETCH: begin
          // A redirect proceeds without ImemReady, abandoning the outstanding fetch.
          if (!Stall && take_s) begin
            if (is_word_aligned(next_pc_s)) begin
              pc_r    <= next_pc_s;
              count_r <= count_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
              state_r     <= ST_ERROR;
              fetch_req_r <= 1'b0;
              misalign_r  <= 1'b1;
            end
          end
        end
        ST_ERROR: begin
          if (ErrClear) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_VECTOR;
            misalign_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          pc_r        <= RESET_VECTOR;
          fetch_req_r <= 1'b0;
          misalign_r  <= 1'b0;
        end
      endcase
    end
  end

  assign PCResult    = pc_r;
  assign FetchReq    = fetch_req_r;
  assign MisalignErr = misalign_r;
  assign FetchCount  = count_r;
  assign State       = state_r;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: directed scenarios then random stimulus against a reference model.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV = 32'h00000000;
  localparam int          CW = 4;

  logic          Clk = 1'b0;
  logic          Reset, BranchTaken, Jump, Stall, ImemReady, ErrClear;
  logic [31:0]   PCAddResult, BranchTarget, JumpTarget;
  logic [31:0]   PCResult;
  logic          FetchReq, MisalignErr;
  logic [CW-1:0] FetchCount;
  logic [1:0]    State;

  pc_fetch_ctrl #(.RESET_VECTOR(RV), .COUNT_WIDTH(CW)) dut (
    .Clk(Clk), .Reset(Reset), .PCAddResult(PCAddResult),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget), .Stall(Stall),
    .ImemReady(ImemReady), .ErrClear(ErrClear), .PCResult(PCResult),
    .FetchReq(FetchReq), .MisalignErr(MisalignErr),
    .FetchCount(FetchCount), .State(State)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0]   pc;
    logic [1:0]    st;
    logic          fr;
    logic          me;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: mode 0 idle, 1 fetching, 2 error; plain integer arithmetic.
  logic [31:0] m_pc = RV;
  int          m_mode = 0;
  int          m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input logic rst, input logic jmp, input logic br, input logic stl,
                      input logic imem, input logic clr, input logic [31:0] jt,
                      input logic [31:0] bt, input logic [1:0] aerr);
    logic [31:0] add;
    logic [31:0] t;
    bit          have;
    exp_t        e;
    @(negedge Clk);
    add = (m_pc + 32'd4) ^ {30'd0, aerr};
    Reset = rst; Jump = jmp; BranchTaken = br; Stall = stl; ImemReady = imem;
    ErrClear = clr; JumpTarget = jt; BranchTarget = bt; PCAddResult = add;
    if (rst) begin
      m_pc = RV; m_mode = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (!stl) begin
        have = 1'b1;
        if (jmp) t = jt;
        else if (br) t = bt;
        else if (imem) t = add;
        else have = 1'b0;
        if (have) begin
          if (t % 4 != 0) m_mode = 2;
          else begin
            m_pc  = t;
            m_cnt = (m_cnt + 1) % (1 << CW);
          end
        end
      end
    end else begin
      if (clr) begin
        m_pc = RV; m_mode = 0;
      end
    end
    e.pc  = m_pc;
    e.st  = (m_mode == 2) ? 2'b10 : (m_mode == 1) ? 2'b01 : 2'b00;
    e.fr  = (m_mode == 1);
    e.me  = (m_mode == 2);
    e.cnt = CW'(m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 2'b00);
  endtask

  task automatic jump_to(input logic [31:0] a);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a, 32'd0, 2'b00);
  endtask

  // Monitor: one output set is presented per edge; compare it against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("PCResult", PCResult, e.pc);
        chk("State", {30'd0, State}, {30'd0, e.st});
        chk("FetchReq", {31'd0, FetchReq}, {31'd0, e.fr});
        chk("MisalignErr", {31'd0, MisalignErr}, {31'd0, e.me});
        chk("FetchCount", {{(32-CW){1'b0}}, FetchCount}, {{(32-CW){1'b0}}, e.cnt});
      end
    end
  end

  initial begin
    logic [31:0] r1, r2;
    logic [31:0] jt, bt;
    logic [1:0]  aerr;
    bit          drained;
    Reset = 1'b1; Jump = 1'b0; BranchTaken = 1'b0; Stall = 1'b0;
    ImemReady = 1'b1; ErrClear = 1'b0; JumpTarget = 32'd0; BranchTarget = 32'd0;
    PCAddResult = 32'd4;

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 2'b00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 2'b00);
    seq(4);
    // Memory wait at 0x10.
    jump_to(32'h10);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
    seq(1);
    // Simultaneous jump and branch, first stalled then taken.
    jump_to(32'h20);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h100, 2'b00);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h100, 2'b00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h300, 2'b00);
    // Adder wrap from the top of the address space.
    jump_to(32'hFFFFFFFC);
    seq(2);
    // Misaligned jump, ignored inputs while trapped, then clear.
    jump_to(32'h40);
    jump_to(32'h41);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h80, 32'h90, 2'b00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 2'b00);
    seq(1);
    // Corrupted sequential PC traps too.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 2'b10);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 2'b00);
    seq(1);
    // Reset during a memory wait at 0x80.
    jump_to(32'h80);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
    // Counter wrap: more than 2^CW updates.
    seq(1 + (1 << CW) + 2);

    for (int i = 0; i < 2000; i++) begin
      r1 = $urandom();
      r2 = $urandom();
      jt = {r1[31:2], 2'b00};
      bt = {r2[31:2], 2'b00};
      if ($urandom_range(15) == 0) jt[1:0] = 2'($urandom_range(3, 1));
      if ($urandom_range(15) == 0) bt[1:0] = 2'($urandom_range(3, 1));
      aerr = ($urandom_range(31) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      step(($urandom_range(63) == 0), ($urandom_range(7) == 0), ($urandom_range(5) == 0),
           ($urandom_range(3) == 0), ($urandom_range(3) != 0), ($urandom_range(3) == 0),
           jt, bt, aerr);
    end

    drained = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (exp_q.size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    checks++;
    if (!drained) begin
      failures++;
      $display("FAIL drain: %0d expectations left, 0 required", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Program-counter register and next-PC controller for the instruction fetch unit. It drives PCResult into the PC adder and instruction memory, and takes PCAddResult (PCResult + 4) back from the adder. It selects the next PC from the sequential, branch or jump source, and holds the PC on stall or memory wait. It traps misaligned targets and counts retired fetches.

Parameters:
RESET_VECTOR, 32'h00000000, PC value loaded on reset and on error clear; must be word-aligned.
COUNT_WIDTH, 16, width of fetch counter.

Ports:
Clk  input  1  system clock; all state updates on rising edge.
Reset  input  1  synchronous, active-high reset.
PCAddResult  input  32  sequential next PC from PC adder (PCResult + 4).
BranchTaken  input  1  redirect to BranchTarget this cycle.
BranchTarget  input  32  branch destination.
Jump  input  1  redirect to JumpTarget this cycle.
JumpTarget  input  32  jump destination.
Stall  input  1  freeze PC (hazard from downstream).
ImemReady  input  1  instruction memory has delivered word at PCResult.
ErrClear  input  1  leave ERROR state.
PCResult  output  32  current PC.
FetchReq  output  1  fetch request to instruction memory.
MisalignErr  output  1  sticky misaligned-target flag.
FetchCount  output  COUNT_WIDTH  number of PC updates since reset.
State  output  2  FSM state: 00 IDLE, 01 FETCH, 10 ERROR.

Behaviour:
- Reset has priority over every input. On the Reset edge: PCResult=RESET_VECTOR, FetchReq=0, MisalignErr=0, FetchCount=0, State=IDLE.
- FetchReq is Moore: 1 only in FETCH. MisalignErr=1 only in ERROR.
- IDLE: PC held. Next edge with Reset=0 goes to FETCH; first request is at RESET_VECTOR.
- FETCH, next-PC select priority: Jump > BranchTaken > PCAddResult.
  - Stall=1: PC, counter and state all held; Jump and BranchTaken are ignored that cycle.
  - Stall=0, Jump or BranchTaken = 1: redirect target is checked. Redirect happens even if ImemReady=0, and the outstanding fetch is abandoned.
  - Stall=0, no redirect, ImemReady=1: PC <= PCAddResult.
  - Stall=0, no redirect, ImemReady=0: PC held (memory wait state).
- Any PC update has 1-cycle latency: the new PCResult is visible after the edge. Each update increments FetchCount by 1.
- FetchCount wraps from 2^COUNT_WIDTH-1 to 0 with no flag.
- Alignment check on the selected next PC:
  - If bits [1:0] != 0: PC is not updated, FetchCount is not incremented, next state is ERROR.
  - This applies to the sequential source too, e.g. a corrupted adder output.
- ERROR: PC holds the last good value; all fetch inputs are ignored.
  - ErrClear=1 gives PCResult <= RESET_VECTOR and State <= IDLE. FetchCount is preserved.
  - ErrClear is ignored outside ERROR.
- Reset asserted in any state, including mid-wait or in ERROR, gives the full reset values on the next edge.
- Arithmetic: no addition inside the block. PC width is 32 bits, and address 32'hFFFFFFFC + 4 = 0 arrives from the adder already wrapped; the block accepts it as aligned.

Test Plan:
- Reset held 2 cycles, then released with ImemReady=1 → State 00 then 01; PCResult 0, 4, 8, 0xC on successive edges; FetchCount 0→3.
- In FETCH at PC=0x10, ImemReady=0 for 3 cycles then 1 → PCResult stays 0x10 during the wait, then 0x14; FetchCount increments once.
- At PC=0x20, BranchTaken=1, BranchTarget=0x100, Jump=1, JumpTarget=0x200 in the same cycle → PCResult=0x200.
- Repeat with Stall=1 → PCResult stays 0x20.
- PCResult=0xFFFFFFFC with the adder feeding 0x00000000 → PCResult wraps to 0x00000000 with no error.
- Jump=1, JumpTarget=0x00000041 at PC=0x40 → PCResult stays 0x40, State=10, MisalignErr=1, FetchReq=0.
- ErrClear=1 → PCResult=0, State=00, FetchCount unchanged.
- Reset pulsed while in a memory wait at PC=0x80 → PCResult=0, FetchCount=0, State=00 next edge.
- Run with COUNT_WIDTH=4 for 16 updates → FetchCount wraps to 0.
